sfr_bank: RTL and testbench
===========================

SFR_BANK -- requirements
Module: sfr_bank

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, the address bus width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the data width in bits; it must be a multiple of 8.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, the number of implemented registers; it must satisfy 1 <= NUM_REGS <= 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter RESET_VALUE, default 0, the DATA_WIDTH-bit value loaded into every register on reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port address, input, ADDR_WIDTH bits: register index for the read and write in the current cycle.
REQ-008 The block SHALL have port write_data, input, DATA_WIDTH bits: write payload.
REQ-009 The block SHALL have port wstrb, input, DATA_WIDTH/8 bits: byte-lane write enables.
REQ-010 The block SHALL have port we, input, 1 bit: write request, sampled each cycle.
REQ-011 The block SHALL have port re, input, 1 bit: read request, sampled each cycle.
REQ-012 The block SHALL have port read_data, output, DATA_WIDTH bits: registered read result.
REQ-013 The block SHALL have port read_valid, output, 1 bit: one-cycle pulse qualifying read_data.
REQ-014 The block SHALL have port write_ack, output, 1 bit: one-cycle pulse acknowledging a write.
REQ-015 The block SHALL have port resp_err, output, 1 bit: qualifies read_valid/write_ack as an out-of-range access.
REQ-016 The block SHALL have port err_count, output, 8 bits: saturating count of out-of-range accesses.

Function
REQ-017 The block SHALL implement NUM_REGS registers of DATA_WIDTH bits; an address is in range when address < NUM_REGS.
REQ-018 An in-range write (we=1 at edge N) SHALL update byte lane i only where wstrb[i]=1; the new value is visible to a read issued at edge N+1.
REQ-019 A write with wstrb all zero SHALL leave the register unchanged and SHALL still be acknowledged.
REQ-020 write_ack SHALL be 1 for exactly the cycle after every sampled we=1, irrespective of address.
REQ-021 A read (re=1 at edge N) SHALL drive read_data and read_valid=1 for the cycle after edge N; latency is fixed at 1 cycle.
REQ-022 read_data SHALL hold its last value while read_valid=0.
REQ-023 When we=1 and re=1 in the same cycle to the same address, the read SHALL return the pre-write contents, and the write SHALL still take effect.
REQ-024 An out-of-range write SHALL modify no register and SHALL be acknowledged with resp_err=1.
REQ-025 An out-of-range read SHALL return read_data=0 with resp_err=1.
REQ-026 resp_err SHALL be 1 in the response cycle if either the read or the write of that request cycle was out of range, and 0 otherwise.
REQ-027 err_count SHALL increment by 1 per out-of-range read and per out-of-range write; a cycle containing both SHALL add 2.
REQ-028 err_count SHALL saturate at 255 and never wrap.
REQ-029 Back-to-back requests on every cycle SHALL be accepted without stall; there is no busy state.

Reset
REQ-030 While reset=1 at a clock edge, all registers SHALL load RESET_VALUE; read_data, read_valid, write_ack, resp_err and err_count SHALL be 0.
REQ-031 A we or re sampled in the same cycle as reset=1 SHALL be discarded, with no pulse produced after reset deasserts.
REQ-032 A response pending from the cycle before reset SHALL be suppressed if reset is high in its output cycle.

Verification
REQ-033 The bench SHALL cover: reset, then read each address 0..15 -> each returns 0x00000000 with read_valid pulse one cycle later and resp_err=0.
REQ-034 The bench SHALL cover: write 0xAABBCCDD to addr 3 with wstrb=4'b1111, then write 0x11223344 with wstrb=4'b0101, then read addr 3 -> 0xAA22CC44.
REQ-035 The bench SHALL cover: same-cycle we/re to addr 5 (old value 0x1, new value 0x2) -> read_data=0x1; the next read returns 0x2.
REQ-036 The bench SHALL cover: read addr 0x20 with NUM_REGS=16 -> read_data=0, resp_err=1, err_count=1; write to addr 0xFF -> write_ack=1, resp_err=1, err_count=2, no register changed.
REQ-037 The bench SHALL cover: 300 out-of-range accesses -> err_count=255 and holds there.
REQ-038 The bench SHALL cover: assert reset in the cycle after re=1 -> read_valid stays 0; all registers read RESET_VALUE afterwards.

Source files
------------

// File: rtl/sfr_bank.sv
// Byte-strobed special function register bank with one-cycle registered
// read/write responses, out-of-range error flagging and a saturating error count.
module sfr_bank #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    we,
    input  logic                    re,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_valid,
    output logic                    write_ack,
    output logic                    resp_err,
    output logic [7:0]              err_count
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_valid;
    logic                  r_write_ack;
    logic                  r_resp_err;
    logic [7:0]            r_err_count;

    logic                  w_in_range;
    logic [IW-1:0]         w_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_rd_err;
    logic                  w_wr_err;
    logic [8:0]            w_err_sum;
    logic [7:0]            w_err_next;

    // Extra top bit lets NUM_REGS == 2**ADDR_WIDTH compare correctly.
    assign w_in_range = {1'b0, address} < (ADDR_WIDTH + 1)'(NUM_REGS);
    assign w_idx      = address[IW-1:0];
    assign w_rd_word  = w_in_range ? r_regs[w_idx] : '0;
    assign w_rd_err   = re & ~w_in_range;
    assign w_wr_err   = we & ~w_in_range;
    assign w_err_sum  = {1'b0, r_err_count} + 9'(w_rd_err) + 9'(w_wr_err);
    assign w_err_next = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RESET_VALUE;
            end
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_write_ack  <= 1'b0;
            r_resp_err   <= 1'b0;
            r_err_count  <= 8'd0;
        end else begin
            r_read_valid <= re;
            r_write_ack  <= we;
            r_resp_err   <= w_rd_err | w_wr_err;
            r_err_count  <= w_err_next;
            if (re) begin
                r_read_data <= w_rd_word;
            end
            for (int i = 0; i < NB; i++) begin
                if (we && w_in_range && wstrb[i]) begin
                    r_regs[w_idx][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    // A response whose output cycle coincides with reset is squashed.
    assign read_valid = r_read_valid & ~reset;
    assign write_ack  = r_write_ack & ~reset;
    assign resp_err   = r_resp_err & ~reset;
    assign read_data  = r_read_data;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_sfr_bank.sv
// Self-checking bench for sfr_bank: vector table plus hand sequences,
// expectations queued at drive time and compared in the response cycle.
module tb_sfr_bank;

    typedef struct {
        logic        rst;
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        ev;
        logic        ea;
        logic        ee;
        logic        cd;
        logic [31:0] ed;
        logic [7:0]  ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  wstrb = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] read_data;
    logic        read_valid;
    logic        write_ack;
    logic        resp_err;
    logic [7:0]  err_count;

    int nvec = 0;
    int nerr = 0;
    vec_t sb[$];

    sfr_bank #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .NUM_REGS   (16),
        .RESET_VALUE(32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write_data(write_data),
        .wstrb     (wstrb),
        .we        (we),
        .re        (re),
        .read_data (read_data),
        .read_valid(read_valid),
        .write_ack (write_ack),
        .resp_err  (resp_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rst, input logic w, input logic r,
        input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
        input logic ev, input logic ea, input logic ee, input logic cd,
        input logic [31:0] ed, input logic [7:0] ec);
        vec_t v;
        v.rst = rst; v.we = w; v.re = r; v.addr = a; v.wd = d; v.ws = s;
        v.ev = ev; v.ea = ea; v.ee = ee; v.cd = cd; v.ed = ed; v.ec = ec;
        return v;
    endfunction

    // Drive one request; check the response of the previous one.
    task automatic cyc(input vec_t v);
        vec_t e;
        @(negedge clk);
        reset = v.rst; we = v.we; re = v.re;
        address = v.addr; write_data = v.wd; wstrb = v.ws;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (v.rst) begin
                e.ev = 1'b0; e.ea = 1'b0; e.ee = 1'b0; e.cd = 1'b0;
            end
            nvec++;
            if (read_valid !== e.ev || write_ack !== e.ea ||
                resp_err !== e.ee || err_count !== e.ec ||
                (e.cd && read_data !== e.ed)) begin
                nerr++;
                $display("FAIL vec%0d: got v%b a%b e%b d%h c%0d want v%b a%b e%b d%h c%0d",
                         nvec, read_valid, write_ack, resp_err, read_data, err_count,
                         e.ev, e.ea, e.ee, e.ed, e.ec);
            end
        end
        sb.push_back(v);
    endtask

    vec_t tbl[15];
    int   cnt;

    initial begin
        tbl[0]  = mk(0,1,0,8'h03,32'hAABBCCDD,4'hF, 0,1,0,0,32'h0,8'd0);
        tbl[1]  = mk(0,1,0,8'h03,32'h11223344,4'h5, 0,1,0,0,32'h0,8'd0);
        tbl[2]  = mk(0,0,1,8'h03,32'h0,4'h0,        1,0,0,1,32'hAA22CC44,8'd0);
        tbl[3]  = mk(0,1,0,8'h05,32'h1,4'hF,        0,1,0,0,32'h0,8'd0);
        tbl[4]  = mk(0,1,1,8'h05,32'h2,4'hF,        1,1,0,1,32'h1,8'd0);
        tbl[5]  = mk(0,0,1,8'h05,32'h0,4'h0,        1,0,0,1,32'h2,8'd0);
        tbl[6]  = mk(0,1,0,8'h05,32'hFFFFFFFF,4'h0, 0,1,0,0,32'h0,8'd0);
        tbl[7]  = mk(0,0,1,8'h05,32'h0,4'h0,        1,0,0,1,32'h2,8'd0);
        tbl[8]  = mk(0,0,1,8'h20,32'h0,4'h0,        1,0,1,1,32'h0,8'd1);
        tbl[9]  = mk(0,1,0,8'hFF,32'hDEADBEEF,4'hF, 0,1,1,0,32'h0,8'd2);
        tbl[10] = mk(0,0,0,8'h00,32'h0,4'h0,        0,0,0,0,32'h0,8'd2);
        tbl[11] = mk(0,0,1,8'h0F,32'h0,4'h0,        1,0,0,1,32'h0,8'd2);
        tbl[12] = mk(0,0,1,8'h03,32'h0,4'h0,        1,0,0,1,32'hAA22CC44,8'd2);
        tbl[13] = mk(0,1,1,8'h10,32'h12345678,4'hF, 1,1,1,1,32'h0,8'd4);
        tbl[14] = mk(0,0,1,8'h03,32'h0,4'h0,        1,0,0,1,32'hAA22CC44,8'd4);

        cyc(mk(1,0,0,0,0,0, 0,0,0,1,0,0));
        cyc(mk(1,1,1,8'h02,32'h5,4'hF, 0,0,0,1,0,0));
        for (int a = 0; a < 16; a++)
            cyc(mk(0,0,1,8'(a),0,0, 1,0,0,1,32'h0,8'd0));

        foreach (tbl[i]) cyc(tbl[i]);

        cnt = 4;
        for (int i = 0; i < 300; i++) begin
            logic r;
            r = (i % 2) == 0;
            cnt = (cnt < 255) ? cnt + 1 : 255;
            cyc(mk(0,~r,r,8'(16 + (i % 240)),$urandom,4'hF,
                   r,~r,1,r,32'h0,8'(cnt)));
        end
        cyc(mk(0,0,0,0,0,0, 0,0,0,0,0,8'd255));
        cyc(mk(0,0,0,0,0,0, 0,0,0,0,0,8'd255));

        cyc(mk(0,0,1,8'h03,0,0, 1,0,0,1,32'hAA22CC44,8'd255));
        cyc(mk(1,1,1,8'h03,32'h77,4'hF, 0,0,0,1,32'h0,8'd0));
        cyc(mk(0,0,0,0,0,0, 0,0,0,0,0,8'd0));
        for (int a = 0; a < 16; a++)
            cyc(mk(0,0,1,8'(a),0,0, 1,0,0,1,32'h0,8'd0));
        cyc(mk(0,0,0,0,0,0, 0,0,0,0,0,8'd0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
